// File: rtl/rf_wr_arbiter_if.sv
// Writeback request bus and register-file write port.
// The arbiter is the slave; writeback sources and the register file are the master.
interface rf_wr_arbiter_if #(
  parameter int N_REQ = 3,
  parameter int XLEN  = 32
);
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ*5-1:0]    req_rd;
  logic [N_REQ*XLEN-1:0] req_data;
  logic [N_REQ-1:0]      req_ready;
  logic                  wr_hold;
  logic [4:0]            rd;
  logic [XLEN-1:0]       DataWr;
  logic                  RFWr;
  logic                  busy;

  modport master (
    output req_valid, req_rd, req_data, wr_hold,
    input  req_ready, rd, DataWr, RFWr, busy
  );

  modport slave (
    input  req_valid, req_rd, req_data, wr_hold,
    output req_ready, rd, DataWr, RFWr, busy
  );
endinterface

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: one grant per cycle, registered write.
// Define RF_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module rf_wr_arbiter #(
  parameter int N_REQ = 3,
  parameter int XLEN  = 32
) (
  input logic           CLK,
  input logic           RST_N,
  rf_wr_arbiter_if.slave bus
);

  logic            found;
  logic [2:0]      gnt_idx;
  logic [4:0]      rd_w;
  logic [XLEN-1:0] data_w;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] data_q;
  logic            rfwr_q;

`ifdef RF_ARB_FIXED_PRIO_EN
  // Lowest asserted index wins; hold and reset suppress any grant.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && bus.req_valid[k]) begin
        found   = 1'b1;
        gnt_idx = 3'(k);
      end
    end
    if (bus.wr_hold || !RST_N) found = 1'b0;
  end
`else
  logic [2:0] ptr_q;
  logic [2:0] ptr_d;
  logic [3:0] idx;
  logic       vbit;

  // Scan from ptr upward, wrapping, for the first valid requester.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    vbit    = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, ptr_q} + 4'(k);
      if (idx >= 4'(N_REQ)) idx = idx - 4'(N_REQ);
      vbit = 1'b0;
      for (int j = 0; j < N_REQ; j++) begin
        if (idx == 4'(j)) vbit = bus.req_valid[j];
      end
      if (!found && vbit) begin
        found   = 1'b1;
        gnt_idx = idx[2:0];
      end
    end
    if (bus.wr_hold || !RST_N) found = 1'b0;
    ptr_d = ptr_q;
    if (found) begin
      if (gnt_idx == 3'(N_REQ - 1)) ptr_d = 3'd0;
      else                          ptr_d = gnt_idx + 3'd1;
    end
  end

  // Priority pointer moves just past the last winner.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) ptr_q <= 3'd0;
    else        ptr_q <= ptr_d;
  end
`endif

  // Select the winner's destination and data fields.
  always_comb begin
    rd_w   = '0;
    data_w = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_idx == 3'(k)) begin
        rd_w   = bus.req_rd[5*k +: 5];
        data_w = bus.req_data[XLEN*k +: XLEN];
      end
    end
  end

  assign bus.req_ready = found ? (N_REQ'(1) << gnt_idx) : '0;
  assign bus.busy      = |(bus.req_valid & ~bus.req_ready);

  // Register the accepted write; writes to x0 are consumed but not enabled.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_q   <= '0;
      data_q <= '0;
      rfwr_q <= 1'b0;
    end else if (found) begin
      rd_q   <= rd_w;
      data_q <= data_w;
      rfwr_q <= |rd_w;
    end else begin
      rfwr_q <= 1'b0;
    end
  end

  assign bus.rd     = rd_q;
  assign bus.DataWr = data_q;
  assign bus.RFWr   = rfwr_q;

endmodule
